// File: rtl/contador_regressivo_if.sv
// Control/status bundle for the loadable down-counter contador_regressivo.
// With CONTADOR_REGRESSIVO_EVT_EN defined the bundle also carries ev_cnt.
interface contador_regressivo_if #(
    parameter int unsigned Size = 8
);
    logic            en;
    logic            load;
    logic [Size-1:0] d;
    logic            start;
    logic            auto_rl;
    logic [Size-1:0] Q;
    logic            tc;
    logic            busy;
    logic            done;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
    logic [Size-1:0] ev_cnt;
`endif

    // Controller side: drives commands, observes count and status.
    modport master (
`ifdef CONTADOR_REGRESSIVO_EVT_EN
        input  ev_cnt,
`endif
        output en, load, d, start, auto_rl,
        input  Q, tc, busy, done
    );

    // Counter side.
    modport slave (
`ifdef CONTADOR_REGRESSIVO_EVT_EN
        output ev_cnt,
`endif
        input  en, load, d, start, auto_rl,
        output Q, tc, busy, done
    );
endinterface

// File: rtl/contador_regressivo.sv
// Loadable down-counter/timer with one-shot or auto-reload operation and a
// registered one-cycle terminal-count pulse. Optional tc event counter is
// enabled by defining CONTADOR_REGRESSIVO_EVT_EN.
module contador_regressivo #(
    parameter int unsigned Size = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    contador_regressivo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [Size-1:0] q, q_n;
    logic [Size-1:0] reload, reload_n;
    logic            tc_r, tc_n;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
    logic [Size-1:0] ev, ev_n;
`endif

    // State, count, reload value and pulse registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            tc_r   <= 1'b0;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
            ev     <= '0;
`endif
        end else begin
            state  <= state_n;
            q      <= q_n;
            reload <= reload_n;
            tc_r   <= tc_n;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
            ev     <= ev_n;
`endif
        end
    end

    // Next state: load beats start, start beats counting.
    always_comb begin
        state_n  = state;
        q_n      = q;
        reload_n = reload;
        tc_n     = 1'b0;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
        ev_n     = ev;
`endif
        if (bus.load) begin
            q_n      = bus.d;
            reload_n = bus.d;
            state_n  = (bus.d != '0) ? RUN : IDLE;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
            ev_n     = '0;
`endif
        end else if (bus.start && (state != RUN)) begin
            q_n     = reload;
            state_n = (reload != '0) ? RUN : IDLE;
        end else if ((state == RUN) && bus.en) begin
            if (q > Size'(1)) begin
                q_n = q - Size'(1);
            end else if (q == Size'(1)) begin
                tc_n = 1'b1;
`ifdef CONTADOR_REGRESSIVO_EVT_EN
                if (ev != '1) ev_n = ev + Size'(1);
`endif
                if (bus.auto_rl) begin
                    q_n = reload;
                end else begin
                    q_n     = '0;
                    state_n = DONE;
                end
            end else begin
                // A zero count in RUN is unreachable; park safely.
                state_n = IDLE;
            end
        end
    end

    assign bus.Q    = q;
    assign bus.tc   = tc_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
`ifdef CONTADOR_REGRESSIVO_EVT_EN
    assign bus.ev_cnt = ev;
`endif
endmodule

// File: tb/tb_contador_regressivo.sv
// Randomized scoreboard bench for contador_regressivo against a behavioural model.
module tb_contador_regressivo;
    localparam int unsigned SIZE = 8;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    contador_regressivo_if #(.Size(SIZE)) bus ();
    contador_regressivo #(.Size(SIZE)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    typedef struct {
        int q;
        int tc;
        int busy;
        int done;
        int ev;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 counting, 2 finished.
    int m_q, m_rl, m_ph, m_tc, m_ev;
    localparam int MAXV = (1 << SIZE) - 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_rl = 0; m_ph = 0; m_tc = 0; m_ev = 0;
    endtask

    task automatic model_step(input int e, input int ld, input int dv,
                              input int st, input int ar);
        m_tc = 0;
        if (ld != 0) begin
            m_q = dv; m_rl = dv; m_ev = 0;
            m_ph = (dv != 0) ? 1 : 0;
        end else if (st != 0 && m_ph != 1) begin
            m_q = m_rl;
            m_ph = (m_rl != 0) ? 1 : 0;
        end else if (m_ph == 1 && e != 0) begin
            if (m_q > 1) m_q = m_q - 1;
            else begin
                m_tc = 1;
                if (m_ev < MAXV) m_ev = m_ev + 1;
                if (ar != 0) m_q = m_rl;
                else begin
                    m_q = 0; m_ph = 2;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic cycle(input int e, input int ld, input int dv, input int st, input int ar);
        exp_t x;
        @(negedge clk);
        bus.en      = e[0];
        bus.load    = ld[0];
        bus.d       = dv[SIZE-1:0];
        bus.start   = st[0];
        bus.auto_rl = ar[0];
        model_step(e, ld, dv, st, ar);
        x.q = m_q; x.tc = m_tc; x.busy = (m_ph == 1) ? 1 : 0;
        x.done = (m_ph == 2) ? 1 : 0; x.ev = m_ev;
        sb.push_back(x);
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.load = 1'b0; bus.d = '0; bus.start = 1'b0; bus.auto_rl = 1'b0;
    endtask

    // Monitor: compare every registered output shortly after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("q",    int'(bus.Q),    x.q);
            chk("tc",   int'(bus.tc),   x.tc);
            chk("busy", int'(bus.busy), x.busy);
            chk("done", int'(bus.done), x.done);
`ifdef CONTADOR_REGRESSIVO_EVT_EN
            chk("ev_cnt", int'(bus.ev_cnt), x.ev);
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        clr_n = 1'b0;
        #1;
        chk("rst_q", int'(bus.Q), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_tc", int'(bus.tc), 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // Idle after reset: enable alone does nothing.
        repeat (5) cycle(1, 0, 0, 0, 0);

        // One-shot from 5, then hold at zero.
        cycle(1, 1, 5, 0, 0);
        repeat (15) cycle(1, 0, 0, 0, 0);

        // Auto-reload from 3 with enable gaps, then continuous.
        cycle(1, 1, 3, 0, 1);
        for (int i = 0; i < 12; i++) cycle((i % 3 == 1) ? 0 : 1, 0, 0, 0, 1);
        repeat (9) cycle(1, 0, 0, 0, 1);

        // Load beats start while running at 4.
        cycle(1, 1, 8, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 9, 1, 0);
        repeat (3) cycle(1, 0, 0, 1, 0);

        // Zero boundary: load 0, start, then load 1.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 1, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        repeat (2) cycle(1, 0, 0, 0, 0);

        // Two auto-reload expiries from 2.
        cycle(1, 1, 2, 0, 1);
        repeat (4) cycle(1, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a long count.
        cycle(1, 1, 200, 0, 0);
        repeat (50) cycle(1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        model_reset();
        chk("arst_q", int'(bus.Q), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_tc", int'(bus.tc), 0);
`ifdef CONTADOR_REGRESSIVO_EVT_EN
        chk("arst_ev", int'(bus.ev_cnt), 0);
`endif
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (3) cycle(1, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int ld, st, e, ar, dv;
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            st = ($urandom_range(0, 9) == 0) ? 1 : 0;
            e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ar = int'($urandom_range(0, 1));
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 6));
            cycle(e, ld, dv, st, ar);
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
